systolic_pe_os: RTL

- Parametrised output-stationary systolic processing element; next generation of the 16-bit PE.
- Forwards A right and B down with one register of delay each.
- Accumulates a multi-term dot product per tile, delimited by `last_in`.
- Shifts finished results out through a per-column drain chain (`c_in` → `c_out`), so results leave the array without stalling compute on the next tile.
- Tiles the existing 2-D array by instantiation.

---
 rtl/systolic_pkg.sv | 35 +++
 rtl/systolic_pe_os_mac.sv | 113 +++++++++++
 rtl/systolic_pe_os.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the output-stationary systolic PE.
// Operand product helper works on widened values and is trimmed by callers.
package systolic_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ACC_W_DEF  = 40;
  localparam int MAX_W      = 64;

  typedef enum logic {
    ACC_IDLE = 1'b0,
    ACC_RUN  = 1'b1
  } acc_state_e;

  // Extend both dw-bit operands to MAX_W and multiply; the low ACC_W bits
  // equal the 2*dw product extended to ACC_W whenever ACC_W >= 2*dw.
  function automatic logic [MAX_W-1:0] ext_product(
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b,
    input logic             signed_mode,
    input int               dw
  );
    int               sh;
    logic [MAX_W-1:0] ax;
    logic [MAX_W-1:0] bx;
    sh = MAX_W - dw;
    ax = a;
    bx = b;
    if (signed_mode) begin
      ax = $unsigned($signed(a << sh) >>> sh);
      bx = $unsigned($signed(b << sh) >>> sh);
    end
    return ax * bx;
  endfunction

endpackage

// File: rtl/systolic_pe_os_mac.sv
// Product register, tile accumulator and overflow tracking.
// Emits the finished sum combinationally on the cycle it is formed.
module pe_mac_stage
  import systolic_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int SIGNED   = 1,
  parameter int PIPE_MUL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              valid_i,
  input  logic              last_i,
  output logic [ACC_W-1:0]  res_o,
  output logic              res_ovf_o,
  output logic              res_valid_o
);

  logic [ACC_W-1:0] prod_c;
  logic [ACC_W-1:0] prod;
  logic             pv;
  logic             pl;

  assign prod_c = ACC_W'(ext_product(MAX_W'(a_i), MAX_W'(b_i),
                                     SIGNED != 0, DATA_W));

  if (PIPE_MUL != 0) begin : g_pipe
    logic [ACC_W-1:0] prod_q;
    logic             pv_q;
    logic             pl_q;

    // Product stage register with its valid/last tags.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prod_q <= '0;
        pv_q   <= 1'b0;
        pl_q   <= 1'b0;
      end else begin
        prod_q <= prod_c;
        pv_q   <= valid_i;
        pl_q   <= last_i;
      end
    end

    assign prod = prod_q;
    assign pv   = pv_q;
    assign pl   = pl_q;
  end else begin : g_comb
    assign prod = prod_c;
    assign pv   = valid_i;
    assign pl   = last_i;
  end

  acc_state_e       st_q;
  acc_state_e       st_d;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] sum;
  logic             carry;
  logic             ovf_q;
  logic             ovf_d;
  logic             add_ovf;
  logic             done;

  assign {carry, sum} = {1'b0, acc_q} + {1'b0, prod};
  assign add_ovf = (SIGNED != 0)
                 ? ((acc_q[ACC_W-1] == prod[ACC_W-1]) &&
                    (sum[ACC_W-1] != acc_q[ACC_W-1]))
                 : carry;

  // Tile FSM: first valid term loads, later ones add; bubbles hold.
  always_comb begin
    st_d  = st_q;
    acc_d = acc_q;
    ovf_d = ovf_q;
    done  = 1'b0;
    if (pv) begin
      unique case (st_q)
        ACC_IDLE: begin
          acc_d = prod;
          ovf_d = 1'b0;
        end
        ACC_RUN: begin
          acc_d = sum;
          ovf_d = ovf_q | add_ovf;
        end
      endcase
      st_d = pl ? ACC_IDLE : ACC_RUN;
      done = pl;
    end
  end

  // Accumulator state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= ACC_IDLE;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign res_o       = acc_d;
  assign res_ovf_o   = ovf_d;
  assign res_valid_o = done;

endmodule

// File: rtl/systolic_pe_os.sv
// Output-stationary systolic PE: operand forwarding, MAC, result
// slot and a one-stage drain chain that gives pass-through priority.
module systolic_pe_os
  import systolic_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int SIGNED   = 1,
  parameter int PIPE_MUL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              valid_in,
  input  logic              last_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              valid_out,
  output logic              last_out,
  input  logic [ACC_W-1:0]  c_in,
  input  logic              c_ovf_in,
  input  logic              c_valid_in,
  output logic [ACC_W-1:0]  c_out,
  output logic              c_ovf_out,
  output logic              c_valid_out,
  output logic              overrun
);

  if (ACC_W < 2 * DATA_W) begin : g_bad_acc
    $error("systolic_pe_os: ACC_W must be >= 2*DATA_W");
  end
  if (ACC_W > MAX_W) begin : g_bad_max
    $error("systolic_pe_os: ACC_W exceeds MAX_W");
  end

  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              v_q;
  logic              l_q;

  // Forwarding registers; they double as the MAC input register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      v_q <= 1'b0;
      l_q <= 1'b0;
    end else begin
      a_q <= a_in;
      b_q <= b_in;
      v_q <= valid_in;
      l_q <= last_in;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign valid_out = v_q;
  assign last_out  = l_q;

  logic [ACC_W-1:0] res;
  logic             res_ovf;
  logic             res_vld;

  pe_mac_stage #(
    .DATA_W   (DATA_W),
    .ACC_W    (ACC_W),
    .SIGNED   (SIGNED),
    .PIPE_MUL (PIPE_MUL)
  ) u_mac (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_i         (a_q),
    .b_i         (b_q),
    .valid_i     (v_q),
    .last_i      (l_q),
    .res_o       (res),
    .res_ovf_o   (res_ovf),
    .res_valid_o (res_vld)
  );

  logic             full_q, full_d;
  logic [ACC_W-1:0] slot_q, slot_d;
  logic             sovf_q, sovf_d;
  logic             ovr_q, ovr_d;
  logic [ACC_W-1:0] c_q, c_d;
  logic             cov_q, cov_d;
  logic             cv_q, cv_d;
  logic             drain;

  // Result slot and drain mux; a full slot only empties when the
  // chain has no pass-through traffic this cycle.
  always_comb begin
    drain  = full_q & ~c_valid_in;
    full_d = full_q & ~drain;
    slot_d = slot_q;
    sovf_d = sovf_q;
    ovr_d  = ovr_q;
    if (res_vld) begin
      if (!full_q || drain) begin
        full_d = 1'b1;
        slot_d = res;
        sovf_d = res_ovf;
      end else begin
        ovr_d = 1'b1;
      end
    end
    cv_d  = c_valid_in | full_q;
    c_d   = c_q;
    cov_d = cov_q;
    if (c_valid_in) begin
      c_d   = c_in;
      cov_d = c_ovf_in;
    end else if (full_q) begin
      c_d   = slot_q;
      cov_d = sovf_q;
    end
  end

  // Slot, sticky overrun and drain output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      slot_q <= '0;
      sovf_q <= 1'b0;
      ovr_q  <= 1'b0;
      c_q    <= '0;
      cov_q  <= 1'b0;
      cv_q   <= 1'b0;
    end else begin
      full_q <= full_d;
      slot_q <= slot_d;
      sovf_q <= sovf_d;
      ovr_q  <= ovr_d;
      c_q    <= c_d;
      cov_q  <= cov_d;
      cv_q   <= cv_d;
    end
  end

  assign c_out       = c_q;
  assign c_ovf_out   = cov_q;
  assign c_valid_out = cv_q;
  assign overrun     = ovr_q;

endmodule
